spi_slave: RTL and testbench

SPI_SLAVE -- requirements
Module: spi_slave

---
 rtl/spi_pkg.sv | 17 +
 rtl/spi_sync.sv | 36 +++
 rtl/spi_slave.sv | 146 ++++++++++++++
 tb/tb_spi_slave.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and constants for the SPI slave
package spi_pkg;

    localparam int SPI_DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2
    } spi_slv_state_t;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } spi_mode_t;

endpackage

// File: rtl/spi_sync.sv
// rtl/spi_sync.sv - multi-flop synchronizer with rise/fall detect
module spi_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic rst_val,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              prev;
    logic [STAGES:0]   vld;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            chain <= {STAGES{rst_val}};
            prev  <= rst_val;
            vld   <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
            prev  <= chain[STAGES-1];
            vld   <= {vld[STAGES-1:0], 1'b1};
        end
    end

    // Edges are suppressed until the preset values have been flushed out,
    // so a level held across reset never looks like a fresh edge.
    assign q    = chain[STAGES-1];
    assign rise = vld[STAGES] & q & ~prev;
    assign fall = vld[STAGES] & ~q & prev;

endmodule

// File: rtl/spi_slave.sv
// rtl/spi_slave.sv - SPI slave, all modes; SPI_SLAVE_OVERRUN_EN adds rx_ack/overrun
module spi_slave
    import spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cpol,
    input  logic                  cpha,
    input  logic [SPI_DATA_W-1:0] tx_data,
    output logic                  tx_load_tick,
    output logic [SPI_DATA_W-1:0] rx_data,
    output logic                  rx_done_tick,
    output logic                  busy,
`ifdef SPI_SLAVE_OVERRUN_EN
    input  logic                  rx_ack,
    output logic                  overrun,
`endif
    input  logic                  sclk,
    input  logic                  ss_n,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  miso_oe
);

    spi_slv_state_t        state;
    spi_mode_t             mode_q;
    logic [SPI_DATA_W-1:0] tx_reg;
    logic [SPI_DATA_W-2:0] rx_reg;
    logic [2:0]            bit_cnt;
    logic                  skip_shift;
`ifdef SPI_SLAVE_OVERRUN_EN
    logic                  rx_pending;
`endif

    logic sclk_q, sclk_rise, sclk_fall;
    logic ss_q, ss_rise, ss_fall;
    logic mosi_q, mosi_rise, mosi_fall;
    logic sync_unused;

    spi_sync #(.STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk(clk), .reset_n(reset_n), .rst_val(cpol), .d(sclk),
        .q(sclk_q), .rise(sclk_rise), .fall(sclk_fall)
    );
    spi_sync #(.STAGES(SYNC_STAGES)) u_sync_ss (
        .clk(clk), .reset_n(reset_n), .rst_val(1'b1), .d(ss_n),
        .q(ss_q), .rise(ss_rise), .fall(ss_fall)
    );
    spi_sync #(.STAGES(SYNC_STAGES)) u_sync_mosi (
        .clk(clk), .reset_n(reset_n), .rst_val(1'b0), .d(mosi),
        .q(mosi_q), .rise(mosi_rise), .fall(mosi_fall)
    );

    assign sync_unused = ^{sclk_q, ss_rise, mosi_rise, mosi_fall};

    logic                  lead_edge, trail_edge, sample_edge, shift_edge;
    logic [SPI_DATA_W-1:0] rx_next;

    always_comb begin
        lead_edge   = mode_q.cpol ? sclk_fall : sclk_rise;
        trail_edge  = mode_q.cpol ? sclk_rise : sclk_fall;
        sample_edge = mode_q.cpha ? trail_edge : lead_edge;
        shift_edge  = mode_q.cpha ? lead_edge : trail_edge;
        rx_next     = {rx_reg, mosi_q};
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            mode_q       <= '0;
            tx_reg       <= '0;
            rx_reg       <= '0;
            bit_cnt      <= '0;
            skip_shift   <= 1'b0;
            rx_data      <= '0;
            rx_done_tick <= 1'b0;
            tx_load_tick <= 1'b0;
`ifdef SPI_SLAVE_OVERRUN_EN
            rx_pending   <= 1'b0;
            overrun      <= 1'b0;
`endif
        end else begin
            rx_done_tick <= 1'b0;
            tx_load_tick <= 1'b0;
`ifdef SPI_SLAVE_OVERRUN_EN
            if (rx_ack) begin
                rx_pending <= 1'b0;
                overrun    <= 1'b0;
            end
`endif
            if (ss_q) begin
                state      <= ST_IDLE;
                bit_cnt    <= '0;
                skip_shift <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: if (ss_fall) state <= ST_LOAD;
                    ST_LOAD: begin
                        tx_reg       <= tx_data;
                        tx_load_tick <= 1'b1;
                        bit_cnt      <= '0;
                        mode_q       <= '{cpol: cpol, cpha: cpha};
                        skip_shift   <= cpha;
                        state        <= ST_SHIFT;
                    end
                    ST_SHIFT: begin
                        if (sample_edge) begin
                            rx_reg  <= rx_next[SPI_DATA_W-2:0];
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
`ifdef SPI_SLAVE_OVERRUN_EN
                                if (rx_pending && !rx_ack) begin
                                    overrun <= 1'b1;
                                end else begin
                                    rx_data      <= rx_next;
                                    rx_done_tick <= 1'b1;
                                    rx_pending   <= 1'b1;
                                end
`else
                                rx_data      <= rx_next;
                                rx_done_tick <= 1'b1;
`endif
                                // The next shift edge belongs to the freshly
                                // loaded byte and must leave its MSB on miso.
                                tx_reg       <= tx_data;
                                tx_load_tick <= 1'b1;
                                skip_shift   <= 1'b1;
                            end
                        end
                        if (shift_edge) begin
                            if (skip_shift) skip_shift <= 1'b0;
                            else tx_reg <= {tx_reg[SPI_DATA_W-2:0], 1'b0};
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign busy    = (state != ST_IDLE);
    assign miso_oe = busy;
    assign miso    = tx_reg[SPI_DATA_W-1];

endmodule

// File: tb/tb_spi_slave.sv
// tb/tb_spi_slave.sv - self-checking bench for spi_slave
module tb_spi_slave;

    logic       clk = 1'b0;
    logic       reset_n, cpol, cpha, sclk, ss_n, mosi;
    logic [7:0] tx_data;
    logic       tx_load_tick, rx_done_tick, busy, miso, miso_oe;
    logic [7:0] rx_data;
`ifdef SPI_SLAVE_OVERRUN_EN
    logic       rx_ack = 1'b0;
    logic       overrun;
`endif

    spi_slave #(.SYNC_STAGES(2)) dut (
        .clk(clk), .reset_n(reset_n), .cpol(cpol), .cpha(cpha),
        .tx_data(tx_data), .tx_load_tick(tx_load_tick),
        .rx_data(rx_data), .rx_done_tick(rx_done_tick), .busy(busy),
`ifdef SPI_SLAVE_OVERRUN_EN
        .rx_ack(rx_ack), .overrun(overrun),
`endif
        .sclk(sclk), .ss_n(ss_n), .mosi(mosi), .miso(miso), .miso_oe(miso_oe)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         done_cnt = 0;
    int         load_cnt = 0;
    int         hp       = 8;
    logic       busy_hi  = 1'b0;
    logic       auto_ack = 1'b1;
    logic [7:0] got_q[$];
    int         load_at_done_q[$];
    logic [7:0] exp_q[$];

    always @(negedge clk) begin
        if (rx_done_tick) begin
            got_q.push_back(rx_data);
            load_at_done_q.push_back(load_cnt);
            done_cnt++;
        end
        if (tx_load_tick) load_cnt++;
        if (busy) busy_hi = 1'b1;
`ifdef SPI_SLAVE_OVERRUN_EN
        if (auto_ack) rx_ack = rx_done_tick;
`endif
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // SPI master: MSB first, per-mode edge order, samples miso at its sample edge.
    task automatic spi_bits(input int nbits, input logic [15:0] out_bits,
                            input bit raise_ss, output logic [15:0] in_bits);
        in_bits = '0;
        sclk = cpol;
        ss_n = 1'b0;
        wait_cyc(hp);
        for (int i = 0; i < nbits; i++) begin
            if (!cpha) begin
                mosi = out_bits[nbits-1-i];
                wait_cyc(hp);
                in_bits = {in_bits[14:0], miso};
                sclk = ~cpol;
                wait_cyc(hp);
                sclk = cpol;
            end else begin
                sclk = ~cpol;
                mosi = out_bits[nbits-1-i];
                wait_cyc(hp);
                in_bits = {in_bits[14:0], miso};
                sclk = cpol;
                wait_cyc(hp);
            end
        end
        if (raise_ss) begin
            wait_cyc(hp);
            ss_n = 1'b1;
            wait_cyc(hp + 2);
        end
    endtask

    task automatic do_xfer(input string tag, input int nbytes,
                           input logic [15:0] mosi_word, input logic [7:0] txb);
        int         d0 = done_cnt;
        int         l0 = load_cnt;
        int         q0 = got_q.size();
        logic [15:0] m;
        logic [15:0] exp_m;
        tx_data = txb;
        spi_bits(8 * nbytes, mosi_word, 1'b1, m);
        if (nbytes == 2) exp_q.push_back(mosi_word[15:8]);
        exp_q.push_back(mosi_word[7:0]);
        exp_m = (nbytes == 2) ? {txb, txb} : {8'h00, txb};
        check({tag, "_done_cnt"}, done_cnt - d0, nbytes);
        check({tag, "_master_rx"}, m, exp_m);
        check({tag, "_load_cnt"}, load_cnt - l0, nbytes + 1);
        check({tag, "_log_size"}, got_q.size(), exp_q.size());
        for (int i = q0; i < got_q.size() && i < exp_q.size(); i++)
            check({tag, "_rx_byte"}, got_q[i], exp_q[i]);
        if (load_at_done_q.size() > q0)
            check({tag, "_start_loads"}, load_at_done_q[q0] - l0, 1);
        check({tag, "_rx_data"}, rx_data, exp_q[$]);
        check({tag, "_miso_oe_end"}, miso_oe, 1'b0);
    endtask

    initial begin
        logic [15:0] dummy;
        int d0, l0;

        reset_n = 1'b0; cpol = 1'b0; cpha = 1'b0;
        sclk = 1'b0; ss_n = 1'b1; mosi = 1'b0; tx_data = 8'h00;
        wait_cyc(5);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_miso_oe", miso_oe, 1'b0);
        check("rst_miso", miso, 1'b0);
        check("rst_done", rx_done_tick, 1'b0);
        check("rst_load", tx_load_tick, 1'b0);
`ifdef SPI_SLAVE_OVERRUN_EN
        check("rst_overrun", overrun, 1'b0);
`endif
        reset_n = 1'b1;
        wait_cyc(10);

        do_xfer("mode0", 1, 16'h003C, 8'hA5);

        for (int md = 1; md < 4; md++) begin
            cpol = md[1]; cpha = md[0]; sclk = cpol;
            wait_cyc(10);
            do_xfer($sformatf("mode%0d", md), 1, 16'h0081, 8'h7E);
        end

        cpol = 1'b0; cpha = 1'b0; sclk = 1'b0;
        wait_cyc(10);
        do_xfer("b2b", 2, 16'h1122, 8'h5A);

        d0 = done_cnt;
        spi_bits(5, 16'h0015, 1'b1, dummy);
        check("abort_done", done_cnt - d0, 0);
        check("abort_rx_data", rx_data, 8'h22);
        check("abort_miso_oe", miso_oe, 1'b0);
        do_xfer("after_abort", 1, 16'h0055, 8'hC3);

        d0 = done_cnt; l0 = load_cnt;
        ss_n = 1'b1;
        wait_cyc(5);
        busy_hi = 1'b0;
        for (int i = 0; i < 16; i++) begin
            sclk = ~sclk;
            wait_cyc(hp);
        end
        check("unsel_done", done_cnt - d0, 0);
        check("unsel_load", load_cnt - l0, 0);
        check("unsel_busy", busy_hi, 1'b0);

        d0 = done_cnt;
        spi_bits(3, 16'h0005, 1'b0, dummy);
        reset_n = 1'b0;
        wait_cyc(3);
        reset_n = 1'b1;
        wait_cyc(20);
        check("rstmid_busy", busy, 1'b0);
        check("rstmid_done", done_cnt - d0, 0);
        check("rstmid_rx_data", rx_data, 8'h00);
        ss_n = 1'b1;
        wait_cyc(10);
        do_xfer("after_rst", 1, 16'h0096, 8'h3C);

        for (int t = 0; t < 6; t++) begin
            int nb;
            cpol = 1'($urandom_range(0, 1));
            cpha = 1'($urandom_range(0, 1));
            sclk = cpol;
            hp = $urandom_range(4, 10);
            nb = $urandom_range(1, 2);
            wait_cyc(10);
            do_xfer($sformatf("rand%0d", t), nb, 16'($urandom), 8'($urandom));
        end
        hp = 8;

`ifdef SPI_SLAVE_OVERRUN_EN
        cpol = 1'b0; cpha = 1'b0; sclk = 1'b0;
        wait_cyc(10);
        auto_ack = 1'b0;
        rx_ack = 1'b0;
        d0 = done_cnt;
        tx_data = 8'h00;
        spi_bits(8, 16'h0012, 1'b1, dummy);
        spi_bits(8, 16'h0034, 1'b1, dummy);
        check("ovr_flag", overrun, 1'b1);
        check("ovr_rx_data", rx_data, 8'h12);
        check("ovr_done", done_cnt - d0, 1);
        rx_ack = 1'b1;
        wait_cyc(1);
        rx_ack = 1'b0;
        wait_cyc(2);
        check("ovr_cleared", overrun, 1'b0);
        check("ovr_rx_hold", rx_data, 8'h12);
        auto_ack = 1'b1;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
